// File: rtl/gray_rd_arbiter.sv
// Round-robin arbiter sharing the gray-image memory read port between two
// requesters, with locked bursts, bounded ownership and owner-routed read data.
module gray_rd_arbiter #(
    parameter int AW        = 6,
    parameter int DW        = 8,
    parameter int MAX_BURST = 9
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    input  logic [DW-1:0] gray_data,
    output logic [1:0]    owner
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          pend0_q, pend0_d;
    logic          pend1_q, pend1_d;

    logic          cur_req;
    logic          cur_lock;
    logic          oth_req;
    logic [AW-1:0] cur_addr;
    logic          at_limit;
    logic          release_now;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        pend0_d     = 1'b0;
        pend1_d     = 1'b0;
        gray_req    = 1'b0;
        gray_addr   = '0;
        cur_req     = 1'b0;
        cur_lock    = 1'b0;
        oth_req     = 1'b0;
        cur_addr    = '0;
        at_limit    = 1'b0;
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req && (!m1_req || !rr_ptr_q)) begin
                    state_d = OWN0;
                end else if (m1_req) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                cur_req  = (state_q == OWN0) ? m0_req  : m1_req;
                cur_lock = (state_q == OWN0) ? m0_lock : m1_lock;
                cur_addr = (state_q == OWN0) ? m0_addr : m1_addr;
                oth_req  = (state_q == OWN0) ? m1_req  : m0_req;

                gray_req  = cur_req;
                gray_addr = cur_req ? cur_addr : '0;
                // Return routing is latched here, at issue, so a hand-over
                // next cycle cannot misdirect the data.
                pend0_d   = cur_req && (state_q == OWN0);
                pend1_d   = cur_req && (state_q == OWN1);

                at_limit    = cur_req && (beat_cnt_q == CW'(MAX_BURST - 1));
                release_now = (!cur_req && !cur_lock) || (at_limit && oth_req);

                if (release_now) begin
                    if (oth_req) begin
                        state_d = (state_q == OWN0) ? OWN1 : OWN0;
                    end else begin
                        state_d = IDLE;
                    end
                    rr_ptr_d   = (state_q == OWN0);
                    beat_cnt_d = '0;
                end else if (at_limit) begin
                    beat_cnt_d = '0;
                end else if (cur_req) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            beat_cnt_q <= '0;
            pend0_q    <= 1'b0;
            pend1_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            pend0_q    <= pend0_d;
            pend1_q    <= pend1_d;
        end
    end

    // Memory presents the addressed pixel in the cycle after the strobe.
    assign m0_rvalid = pend0_q;
    assign m1_rvalid = pend1_q;
    assign m0_rdata  = pend0_q ? gray_data : '0;
    assign m1_rdata  = pend1_q ? gray_data : '0;
    assign m0_gnt    = (state_q == OWN0);
    assign m1_gnt    = (state_q == OWN1);
    assign owner     = state_q;

endmodule
